datapath_regs: RTL and testbench
================================

// Module: datapath_regs
// PURPOSE
//  Architectural register datapath executing the per-cycle transfer commands issued by the control FSM.
//  Holds PC, SP, MA, MD, IR, A, AP and OUT.
//  Drives the async-read data memory port and feeds IR back to the control FSM as its opcode.
//  Feeds A/MD to the ALU and captures its result.
// PARAMETERS
//  DATA_W   8      data path width (A, MD, IR, OUT)
//  ADDR_W   8      address width (PC, SP, MA, AP)
//  PC_INIT  0      PC value after reset
//  SP_INIT  'hFF   SP value after reset (empty stack, grows down)
// PORTS
//  i_clk          in   1       clock, all state on rising edge
//  i_rstn         in   1       asynchronous, active-low reset
//  i_transfer_cmd in   4       transfer code 0..F (table below)
//  i_inc_pc       in   1       PC <= PC+1
//  i_inc_dec_sp   in   2       01: SP+1, 10: SP-1, 00/11: hold
//  i_dst_ap       in   1       cmd 5/A target AP instead of A
//  i_reset_ir     in   1       clear IR to 0
//  i_alu_result   in   DATA_W  ALU result R
//  i_in           in   DATA_W  input port
//  i_mem_rdata    in   DATA_W  memory read data, combinational from o_mem_addr
//  o_mem_addr     out  ADDR_W  = MA
//  o_mem_wdata    out  DATA_W  = MD
//  o_mem_we       out  1       high in the cycle cmd==9
//  o_ir           out  DATA_W  IR, opcode to control FSM
//  o_a            out  DATA_W  accumulator, ALU operand
//  o_md           out  DATA_W  MD, ALU operand
//  o_out          out  DATA_W  output port register
//  o_out_valid    out  1       1-cycle pulse after OUT load
//  o_stack_err    out  1       sticky stack fault (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: PC=PC_INIT, SP=SP_INIT; MA, MD, IR, A, AP, OUT = 0; o_out_valid=0, o_stack_err=0.
//  - One command per cycle; effect visible the cycle after. No stalls, no handshake.
//  - Transfer codes:
//      0 nop
//      1 MA<=PC
//      2 MD<=mem[MA]
//      3 IR<=MD
//      4 MA<=MD
//      5 A|AP<=MD
//      6 MA<=AP
//      7 MA<=SP
//      8 MD<=A|AP (source sel i_dst_ap)
//      9 mem write
//      A A|AP<=R
//      B PC<=MD
//      C A<=i_in
//      D OUT<=A, o_out_valid next cycle
//      E PC<=AP
//      F MD<=PC
//  - Width rules:
//      - DATA_W->ADDR_W zero-extends or truncates LSBs.
//      - ADDR_W->DATA_W truncates to the low DATA_W bits.
//  - PC increment is modulo 2^ADDR_W.
//  - Simultaneous events:
//      - cmd B or E with i_inc_pc=1: the load wins; the increment is dropped.
//      - i_reset_ir with cmd 3: the clear wins.
//  - SP updates in parallel with any command. Cmd 7 in the same cycle samples the pre-update SP.
//  - o_mem_we is combinational from cmd and is never asserted during reset.
//  - Async reset mid-command aborts it: no partial writes, registers go to reset values immediately.
// CONFIGURATION
//  DATAPATH_STACK_GUARD_EN
//    Defined:
//      - SP-1 at SP=0 or SP+1 at SP=SP_INIT holds SP and sets o_stack_err.
//      - o_stack_err stays set until reset.
//    Undefined:
//      - SP wraps modulo 2^ADDR_W.
//      - o_stack_err is tied 0.
// TESTING
//  1. Reset, i_rstn=0 mid-sequence -> all regs at reset values; o_mem_we=0; PC=0, SP=FF.
//  2. Fetch: mem[0]=8'h19, cmds 1; 2+inc_pc; 3 -> o_ir=8'h19, PC=1, MA=0.
//  3. Store: A=8'h5A, MA=8'h40, cmds 8; 9 -> o_mem_we=1 for exactly one cycle, addr 40, wdata 5A.
//  4. Jump priority: MD=8'h80, cmd B + inc_pc=1 -> PC=80, not 81.
//  5. Stack: SP=0 with dec.
//       - Guard defined: SP=0, o_stack_err=1 sticky.
//       - Guard undefined: SP=FF, o_stack_err=0.
//  6. I/O: i_in=8'h3C, cmd C then D -> o_out=3C, o_out_valid pulses one cycle.

Source files
------------

// File: rtl/datapath_regs.sv
// datapath_regs: architectural register file (PC, SP, MA, MD, IR, A, AP, OUT) executing one transfer command per cycle.
//   Ports: i_clk, i_rstn (async active-low); i_transfer_cmd, i_inc_pc, i_inc_dec_sp, i_dst_ap, i_reset_ir from control;
//   i_alu_result, i_in, i_mem_rdata data inputs; o_mem_addr/o_mem_wdata/o_mem_we memory port;
//   o_ir opcode, o_a/o_md ALU operands, o_out/o_out_valid output port, o_stack_err stack fault.
//   Optional macro DATAPATH_STACK_GUARD_EN: saturate SP at its bounds and flag a sticky o_stack_err.
module datapath_regs #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] PC_INIT = '0,
    parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'('hFF)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [3:0]        i_transfer_cmd,
    input  logic              i_inc_pc,
    input  logic [1:0]        i_inc_dec_sp,
    input  logic              i_dst_ap,
    input  logic              i_reset_ir,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_in,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_ir,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_md,
    output logic [DATA_W-1:0] o_out,
    output logic              o_out_valid,
    output logic              o_stack_err
);
    logic [ADDR_W-1:0] pc, sp, ma, ap, sp_next;
    logic [DATA_W-1:0] md, ir, a, out;
    logic out_valid, stack_err, sp_inc, sp_dec, sp_fault;

    assign sp_inc = i_inc_dec_sp == 2'b01;
    assign sp_dec = i_inc_dec_sp == 2'b10;
`ifdef DATAPATH_STACK_GUARD_EN
    assign sp_fault = (sp_inc && sp == SP_INIT) || (sp_dec && sp == '0);
`else
    assign sp_fault = 1'b0;
`endif
    assign sp_next = sp_fault ? sp : sp_inc ? sp + ADDR_W'(1) : sp_dec ? sp - ADDR_W'(1) : sp;

    // gated by reset so an aborted store never reaches memory
    assign o_mem_we    = i_rstn && i_transfer_cmd == 4'h9;
    assign o_mem_addr  = ma;
    assign o_mem_wdata = md;
    assign o_ir        = ir;
    assign o_a         = a;
    assign o_md        = md;
    assign o_out       = out;
    assign o_out_valid = out_valid;
    assign o_stack_err = stack_err;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pc        <= PC_INIT;
            sp        <= SP_INIT;
            ma        <= '0;
            md        <= '0;
            ir        <= '0;
            a         <= '0;
            ap        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            if (i_inc_pc) pc <= pc + ADDR_W'(1);
            sp        <= sp_next;
            stack_err <= stack_err | sp_fault;
            out_valid <= i_transfer_cmd == 4'hD;
            // later assignments override: PC loads beat the increment
            case (i_transfer_cmd)
                4'h1: ma <= pc;
                4'h2: md <= i_mem_rdata;
                4'h3: ir <= md;
                4'h4: ma <= ADDR_W'(md);
                4'h5: if (i_dst_ap) ap <= ADDR_W'(md); else a <= md;
                4'h6: ma <= ap;
                4'h7: ma <= sp;
                4'h8: md <= i_dst_ap ? DATA_W'(ap) : a;
                4'hA: if (i_dst_ap) ap <= ADDR_W'(i_alu_result); else a <= i_alu_result;
                4'hB: pc <= ADDR_W'(md);
                4'hC: a <= i_in;
                4'hD: out <= a;
                4'hE: pc <= ap;
                4'hF: md <= DATA_W'(pc);
                default: ;
            endcase
            if (i_reset_ir) ir <= '0;
        end
    end
endmodule

// File: tb/tb_datapath_regs.sv
// tb_datapath_regs: table-driven, directed and random checks of datapath_regs against a reference model.
module tb_datapath_regs;
`ifdef DATAPATH_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    logic       i_clk = 1'b0, i_rstn = 1'b0;
    logic [3:0] i_transfer_cmd = '0;
    logic       i_inc_pc = 1'b0, i_dst_ap = 1'b0, i_reset_ir = 1'b0;
    logic [1:0] i_inc_dec_sp = '0;
    logic [7:0] i_alu_result = '0, i_in = '0, i_mem_rdata;
    logic [7:0] o_mem_addr, o_mem_wdata, o_ir, o_a, o_md, o_out;
    logic       o_mem_we, o_out_valid, o_stack_err;

    datapath_regs dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_transfer_cmd(i_transfer_cmd), .i_inc_pc(i_inc_pc),
        .i_inc_dec_sp(i_inc_dec_sp), .i_dst_ap(i_dst_ap), .i_reset_ir(i_reset_ir),
        .i_alu_result(i_alu_result), .i_in(i_in), .i_mem_rdata(i_mem_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_ir(o_ir),
        .o_a(o_a), .o_md(o_md), .o_out(o_out), .o_out_valid(o_out_valid), .o_stack_err(o_stack_err)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] mem [256];
    assign i_mem_rdata = mem[o_mem_addr];
    always @(posedge i_clk) if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;

    int checks = 0, errors = 0;
    int m_pc, m_sp, m_ma, m_md, m_ir, m_a, m_ap, m_out, m_ov, m_err;
    int mm [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_pc = 0; m_sp = 255; m_ma = 0; m_md = 0; m_ir = 0;
        m_a = 0; m_ap = 0; m_out = 0; m_ov = 0; m_err = 0;
    endfunction

    // next architectural state from the transfer table, computed on integers
    function automatic void m_step(int c, int inc, int spc, int dap, int rir, int alu, int inn);
        int pc = m_pc, sp = m_sp, ma = m_ma, md = m_md, ir = m_ir, a = m_a, ap = m_ap, out = m_out;
        case (c)
            1: ma = pc;
            2: md = mm[ma];
            3: ir = md;
            4: ma = md;
            5: if (dap != 0) ap = md; else a = md;
            6: ma = ap;
            7: ma = sp;
            8: md = dap != 0 ? ap : a;
            9: mm[ma] = md;
            10: if (dap != 0) ap = alu; else a = alu;
            11: pc = md;
            12: a = inn;
            13: out = a;
            14: pc = ap;
            15: md = pc;
            default: ;
        endcase
        if (inc != 0 && c != 11 && c != 14) pc = (m_pc + 1) % 256;
        if (rir != 0) ir = 0;
        if (spc == 1) begin
            if (GUARD && m_sp == 255) m_err = 1; else sp = (m_sp + 1) % 256;
        end else if (spc == 2) begin
            if (GUARD && m_sp == 0) m_err = 1; else sp = (m_sp + 255) % 256;
        end
        m_pc = pc; m_sp = sp; m_ma = ma; m_md = md; m_ir = ir;
        m_a = a; m_ap = ap; m_out = out; m_ov = (c == 13) ? 1 : 0;
    endfunction

    task automatic cmp_model();
        chk("addr", 32'(o_mem_addr), m_ma);
        chk("md", 32'(o_md), m_md);
        chk("wdata", 32'(o_mem_wdata), m_md);
        chk("ir", 32'(o_ir), m_ir);
        chk("a", 32'(o_a), m_a);
        chk("out", 32'(o_out), m_out);
        chk("out_valid", 32'(o_out_valid), m_ov);
        chk("stack_err", 32'(o_stack_err), m_err);
    endtask

    // drive one command just after an edge, check the store strobe, then the post-edge state
    task automatic cyc(input logic [3:0] c, input logic inc = 1'b0, input logic [1:0] spc = 2'b00,
                       input logic dap = 1'b0, input logic rir = 1'b0,
                       input logic [7:0] alu = 8'h00, input logic [7:0] inn = 8'h00);
        i_transfer_cmd = c; i_inc_pc = inc; i_inc_dec_sp = spc; i_dst_ap = dap;
        i_reset_ir = rir; i_alu_result = alu; i_in = inn;
        #1;
        chk("we", 32'(o_mem_we), (c == 4'h9) ? 1 : 0);
        m_step(int'(c), int'(inc), int'(spc), int'(dap), int'(rir), int'(alu), int'(inn));
        @(posedge i_clk);
        #1;
        cmp_model();
    endtask

    typedef struct {
        logic [3:0] c; logic inc; logic [1:0] spc; logic dap; logic rir;
        logic [7:0] alu, inn;
        logic [7:0] e_addr, e_md, e_ir, e_a, e_out; logic e_ov;
    } vec_t;
    vec_t tbl [$];

    task automatic do_reset();
        i_rstn = 1'b0;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; mm[i] = 0; end
        mem[0] = 8'h19; mm[0] = 'h19;
        m_reset();
        i_transfer_cmd = '0; i_inc_pc = 0; i_inc_dec_sp = 0; i_dst_ap = 0; i_reset_ir = 0;
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
    endtask

    initial begin
        logic [7:0] gfe, gff, g00;
        gff = GUARD ? 8'hFF : 8'h00;
        g00 = GUARD ? 8'hFF : 8'h00;
        gfe = GUARD ? 8'hFE : 8'hFF;
        //              c    inc spc dap rir alu    in     addr   md     ir     a      out    ov
        tbl.push_back('{4'h1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0});
        tbl.push_back('{4'h2, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h19, 8'h00, 8'h00, 8'h00, 0});
        tbl.push_back('{4'h3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h19, 8'h19, 8'h00, 8'h00, 0});
        tbl.push_back('{4'hF, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h19, 8'h00, 8'h00, 0});
        tbl.push_back('{4'h7, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h19, 8'h00, 8'h00, 0});
        tbl.push_back('{4'hC, 0, 0, 0, 0, 8'h00, 8'h5A, 8'hFF, 8'h01, 8'h19, 8'h5A, 8'h00, 0});
        tbl.push_back('{4'hA, 0, 0, 1, 0, 8'h40, 8'h00, 8'hFF, 8'h01, 8'h19, 8'h5A, 8'h00, 0});
        tbl.push_back('{4'h6, 0, 0, 0, 0, 8'h00, 8'h00, 8'h40, 8'h01, 8'h19, 8'h5A, 8'h00, 0});
        tbl.push_back('{4'h8, 0, 0, 0, 0, 8'h00, 8'h00, 8'h40, 8'h5A, 8'h19, 8'h5A, 8'h00, 0});
        tbl.push_back('{4'h9, 0, 0, 0, 0, 8'h00, 8'h00, 8'h40, 8'h5A, 8'h19, 8'h5A, 8'h00, 0});
        tbl.push_back('{4'hA, 0, 0, 0, 0, 8'h77, 8'h00, 8'h40, 8'h5A, 8'h19, 8'h77, 8'h00, 0});
        tbl.push_back('{4'h8, 0, 0, 0, 0, 8'h00, 8'h00, 8'h40, 8'h77, 8'h19, 8'h77, 8'h00, 0});
        tbl.push_back('{4'h2, 0, 0, 0, 0, 8'h00, 8'h00, 8'h40, 8'h5A, 8'h19, 8'h77, 8'h00, 0});
        tbl.push_back('{4'hD, 0, 0, 0, 0, 8'h00, 8'h00, 8'h40, 8'h5A, 8'h19, 8'h77, 8'h77, 1});
        tbl.push_back('{4'h0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h40, 8'h5A, 8'h19, 8'h77, 8'h77, 0});
        tbl.push_back('{4'h4, 0, 0, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h19, 8'h77, 8'h77, 0});
        tbl.push_back('{4'hB, 1, 0, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h19, 8'h77, 8'h77, 0});
        tbl.push_back('{4'hA, 0, 0, 0, 0, 8'h33, 8'h00, 8'h5A, 8'h5A, 8'h19, 8'h33, 8'h77, 0});
        tbl.push_back('{4'h8, 0, 0, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h33, 8'h19, 8'h33, 8'h77, 0});
        tbl.push_back('{4'hF, 0, 0, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h19, 8'h33, 8'h77, 0});
        tbl.push_back('{4'hE, 1, 0, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h19, 8'h33, 8'h77, 0});
        tbl.push_back('{4'hF, 0, 0, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h40, 8'h19, 8'h33, 8'h77, 0});
        tbl.push_back('{4'h3, 0, 0, 0, 1, 8'h00, 8'h00, 8'h5A, 8'h40, 8'h00, 8'h33, 8'h77, 0});
        tbl.push_back('{4'h0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h5A, 8'h40, 8'h00, 8'h33, 8'h77, 0});
        tbl.push_back('{4'h7, 0, 0, 0, 0, 8'h00, 8'h00, gff,   8'h40, 8'h00, 8'h33, 8'h77, 0});
        tbl.push_back('{4'h7, 0, 2, 0, 0, 8'h00, 8'h00, g00,   8'h40, 8'h00, 8'h33, 8'h77, 0});
        tbl.push_back('{4'h7, 0, 0, 0, 0, 8'h00, 8'h00, gfe,   8'h40, 8'h00, 8'h33, 8'h77, 0});

        do_reset();
        chk("rst_we", 32'(o_mem_we), 0);
        cmp_model();
        foreach (tbl[i]) begin
            cyc(tbl[i].c, tbl[i].inc, tbl[i].spc, tbl[i].dap, tbl[i].rir, tbl[i].alu, tbl[i].inn);
            chk($sformatf("t%0d_addr", i), 32'(o_mem_addr), 32'(tbl[i].e_addr));
            chk($sformatf("t%0d_md", i), 32'(o_md), 32'(tbl[i].e_md));
            chk($sformatf("t%0d_ir", i), 32'(o_ir), 32'(tbl[i].e_ir));
            chk($sformatf("t%0d_a", i), 32'(o_a), 32'(tbl[i].e_a));
            chk($sformatf("t%0d_out", i), 32'(o_out), 32'(tbl[i].e_out));
            chk($sformatf("t%0d_ov", i), 32'(o_out_valid), 32'(tbl[i].e_ov));
        end
        chk("mem40", 32'(mem[8'h40]), 32'h5A);

        // asynchronous reset in the middle of a store cycle
        i_transfer_cmd = 4'h9; #2;
        i_rstn = 1'b0; #1;
        chk("async_we", 32'(o_mem_we), 0);
        chk("async_a", 32'(o_a), 0);
        chk("async_md", 32'(o_md), 0);
        chk("async_addr", 32'(o_mem_addr), 0);
        chk("async_out", 32'(o_out), 0);
        m_reset();
        @(posedge i_clk); #1;
        chk("async_mem", 32'(mem[8'h00]), 32'h19);
        i_rstn = 1'b1;
        cyc(4'hF);
        chk("rst_pc", 32'(o_md), 0);
        cyc(4'h7);
        chk("rst_sp", 32'(o_mem_addr), 32'hFF);

        // walk SP down to 0, then one more decrement
        for (int i = 0; i < 255; i++) cyc(4'h0, 0, 2'b10);
        cyc(4'h7);
        chk("sp_zero", 32'(o_mem_addr), 0);
        cyc(4'h0, 0, 2'b10);
        cyc(4'h7);
        chk("sp_under", 32'(o_mem_addr), GUARD ? 0 : 32'hFF);
        chk("err_set", 32'(o_stack_err), GUARD ? 1 : 0);
        cyc(4'h0, 0, 2'b01);
        cyc(4'h0);
        chk("err_sticky", 32'(o_stack_err), GUARD ? 1 : 0);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            cyc(4'($urandom_range(0, 15)), 1'($urandom), 2'($urandom), 1'($urandom),
                1'($urandom_range(0, 7) == 0), 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
